// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI flash reader: FSM encoding and flash opcodes.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_MODE   = 3'd3,
    ST_DUMMY  = 3'd4,
    ST_DATA   = 3'd5,
    ST_RESP   = 3'd6,
    ST_CSHOLD = 3'd7
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_QREAD = 8'hEB;
  localparam logic [7:0] MODE_BITS = 8'h00;

endpackage

// File: rtl/qspi_sclk_gen.sv
// SPI mode-0 clock generator: SCLK idles low while disabled, toggles every CLK_DIV cycles when enabled.
module qspi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  // rise/fall flag the edge on which sclk is about to change, so the FSM acts in step with it
  assign tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  always_ff @(posedge ACLK) begin
    if (ARESET || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/qspi_flash_reader.sv
// AXI4-Lite read-only slave turning each AR request into one SPI flash read.
// Define QSPI_QUAD_EN for quad I/O fast read (EBh); otherwise single-lane read (03h).
module qspi_flash_reader
  import qspi_pkg::*;
#(
  parameter int ADDR_SIZE    = 24,
  parameter int DATA_SIZE    = 32,
  parameter int CLK_DIV      = 2,
  parameter int DUMMY_CYCLES = 4,
  parameter int CS_HIGH_MIN  = 2
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [ADDR_SIZE-1:0] araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [DATA_SIZE-1:0] rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 spi_sclk,
  output logic                 spi_cs_n,
  output logic [3:0]           io_out,
  output logic [3:0]           io_oe,
  input  logic [3:0]           io_in,
  output logic [2:0]           state_dbg
);

`ifdef QSPI_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif

  localparam int         ADDR_LEN = QUAD ? ADDR_SIZE / 4 : ADDR_SIZE;
  localparam int         DATA_LEN = QUAD ? DATA_SIZE / 4 : DATA_SIZE;
  localparam logic [7:0] CMD_BYTE = QUAD ? CMD_QREAD : CMD_READ;
  localparam int         TX_W     = 8 + ADDR_SIZE + 8;
  localparam int         CNT_W    = $clog2(ADDR_SIZE + DATA_SIZE + DUMMY_CYCLES + 8);
  localparam int         CSC_W    = $clog2(CS_HIGH_MIN + 2);

  state_t               state, next_state;
  logic                 sclk_en, rise, fall, handshake, phase_last;
  logic [TX_W-1:0]      tx_sr, tx_next;
  logic [DATA_SIZE-1:0] rx_sr, rx_next, rx_swapped;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CSC_W-1:0]     cs_cnt;

  qspi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .en     (sclk_en),
    .sclk   (spi_sclk),
    .rise   (rise),
    .fall   (fall)
  );

  assign rresp     = 2'b00;
  assign handshake = (state == ST_IDLE) && arvalid && arready;
  // Command bits always go out one per SCLK; later quad fields move a nibble per SCLK
  assign tx_next   = (QUAD && state != ST_CMD) ? {tx_sr[TX_W-5:0], 4'h0} : {tx_sr[TX_W-2:0], 1'b0};

`ifdef QSPI_QUAD_EN
  assign rx_next = {rx_sr[DATA_SIZE-5:0], io_in};
`else
  logic unused_io;
  assign rx_next   = {rx_sr[DATA_SIZE-2:0], io_in[1]};
  assign unused_io = ^{io_in[3:2], io_in[0]};
`endif

  // First flash byte arrives in the top of rx_sr but belongs in rdata[7:0]
  always_comb begin
    rx_swapped = '0;
    for (int k = 0; k < DATA_SIZE / 8; k++)
      rx_swapped[8*k +: 8] = rx_sr[DATA_SIZE-1-8*k -: 8];
  end

  always_comb begin
    phase_last = 1'b0;
    case (state)
      ST_CMD:   phase_last = (bit_cnt == CNT_W'(7));
      ST_ADDR:  phase_last = (bit_cnt == CNT_W'(ADDR_LEN - 1));
      ST_MODE:  phase_last = (bit_cnt == CNT_W'(1));
      ST_DUMMY: phase_last = (bit_cnt == CNT_W'(DUMMY_CYCLES - 1));
      ST_DATA:  phase_last = (bit_cnt == CNT_W'(DATA_LEN - 1));
      default:  phase_last = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Phases advance on the SCLK fall that closes their last bit
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (handshake) next_state = ST_CMD;
      ST_CMD:    if (fall && phase_last) next_state = ST_ADDR;
      ST_ADDR:   if (fall && phase_last) next_state = QUAD ? ST_MODE : ST_DATA;
      ST_MODE:   if (fall && phase_last) next_state = (DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
      ST_DUMMY:  if (fall && phase_last) next_state = ST_DATA;
      ST_DATA:   if (fall && phase_last) next_state = ST_RESP;
      ST_RESP:   if (rready) next_state = ST_CSHOLD;
      ST_CSHOLD: if (cs_cnt >= CSC_W'(CS_HIGH_MIN)) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    sclk_en   = state inside {ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA};
    io_oe     = 4'b1101;
    io_out    = 4'b1100;
    state_dbg = state;
    case (state)
      ST_CMD:   io_out = {3'b110, tx_sr[TX_W-1]};
      ST_ADDR: begin
        io_oe  = QUAD ? 4'b1111 : 4'b1101;
        io_out = QUAD ? tx_sr[TX_W-1 -: 4] : {3'b110, tx_sr[TX_W-1]};
      end
      ST_MODE: begin
        io_oe  = 4'b1111;
        io_out = tx_sr[TX_W-1 -: 4];
      end
      ST_DUMMY: io_oe = 4'b0000;
      ST_DATA:  io_oe = QUAD ? 4'b0000 : 4'b1101;
      default: ;
    endcase
  end

  // cs_cnt counts cycles with cs_n high, starting at 1 in the first high cycle
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      spi_cs_n <= 1'b1;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      cs_cnt   <= '0;
    end else begin
      arready <= (next_state == ST_IDLE);
      if (state != next_state) bit_cnt <= '0;
      else if (fall)           bit_cnt <= bit_cnt + 1'b1;
      if (handshake) begin
        tx_sr    <= {CMD_BYTE, araddr, MODE_BITS};
        spi_cs_n <= 1'b0;
      end else if (fall && (state inside {ST_CMD, ST_ADDR, ST_MODE})) begin
        tx_sr <= tx_next;
      end
      if (rise && state == ST_DATA) rx_sr <= rx_next;
      if (state == ST_DATA && next_state == ST_RESP) begin
        rvalid   <= 1'b1;
        spi_cs_n <= 1'b1;
        rdata    <= rx_swapped;
        cs_cnt   <= CSC_W'(1);
      end else if (spi_cs_n && cs_cnt != '1) begin
        cs_cnt <= cs_cnt + 1'b1;
      end
      if (state == ST_RESP && rready) rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Directed bench for qspi_flash_reader with a behavioural SPI/QSPI flash model.
module tb_qspi_flash_reader;

`ifdef QSPI_QUAD_EN
  localparam int EXP_LAT   = 112;
  localparam int EXP_RISES = 28;
`else
  localparam int EXP_LAT   = 256;
  localparam int EXP_RISES = 64;
`endif
  localparam int CS_MIN = 2;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [23:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        spi_sclk, spi_cs_n;
  logic [3:0]  io_out, io_oe, io_in;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_bytes [4];
  logic [3:0] rise_io [64];
  int         rises      = 0;
  int         falls      = 0;
  int         sclk_edges = 0;

  qspi_flash_reader #(
    .ADDR_SIZE(24), .DATA_SIZE(32), .CLK_DIV(2), .DUMMY_CYCLES(4), .CS_HIGH_MIN(CS_MIN)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .io_out(io_out), .io_oe(io_oe),
    .io_in(io_in), .state_dbg(state_dbg)
  );

  always #5 ACLK = ~ACLK;

  // Flash model: restarts on cs_n fall, samples the master on SCLK rise, drives data on SCLK fall
  always @(negedge spi_cs_n) begin
    rises = 0;
    falls = 0;
  end

  always @(posedge spi_sclk) begin
    sclk_edges++;
    if (spi_cs_n === 1'b0) begin
      if (rises < 64) rise_io[rises] = io_out;
      rises++;
    end
  end

  always @(negedge spi_sclk) begin
    int i;
    logic [7:0] b;
    if (spi_cs_n === 1'b0) begin
      falls++;
`ifdef QSPI_QUAD_EN
      if (falls >= 20 && falls - 20 < 8) begin
        i = falls - 20;
        b = model_bytes[i / 2];
        io_in = (i % 2 == 0) ? b[7:4] : b[3:0];
      end
`else
      if (falls >= 32 && falls - 32 < 32) begin
        i = falls - 32;
        b = model_bytes[i / 8];
        io_in = {2'b00, b[7 - (i % 8)], 1'b0};
      end
`endif
    end
  end

  task automatic do_handshake(input logic [23:0] addr, output bit ok);
    ok = 1'b0;
    @(negedge ACLK);
    araddr  = addr;
    arvalid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (arready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge ACLK);
    end
    if (ok) begin
      @(posedge ACLK);
      #1;
    end
    arvalid = 1'b0;
  endtask

  task automatic wait_rvalid(output int lat);
    lat = 0;
    while (rvalid !== 1'b1 && lat < 2000) begin
      @(posedge ACLK);
      #1;
      lat++;
    end
    if (rvalid !== 1'b1) lat = -1;
  endtask

  task automatic release_resp();
    @(negedge ACLK);
    rready = 1'b1;
    @(posedge ACLK);
    #1;
    rready = 1'b0;
    repeat (4) @(posedge ACLK);
  endtask

  task automatic test_reset();
    ARESET  = 1'b1;
    arvalid = 1'b1;
    araddr  = 24'h123456;
    rready  = 1'b0;
    io_in   = 4'h0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (spi_sclk !== 1'b0) begin failures++; $display("[TB] FAIL reset_sclk: got %b want 0", spi_sclk); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid: got %b want 0", rvalid); end
    checks++; if (arready !== 1'b0) begin failures++; $display("[TB] FAIL reset_arready: got %b want 0", arready); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (io_out !== 4'b1100) begin failures++; $display("[TB] FAIL reset_io_out: got %b want 1100", io_out); end
    checks++; if (io_oe !== 4'b1101) begin failures++; $display("[TB] FAIL reset_io_oe: got %b want 1101", io_oe); end
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("[TB] FAIL reset_state: got %0d want 0", state_dbg); end
    arvalid = 1'b0;
    ARESET  = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    checks++; if (arready !== 1'b1) begin failures++; $display("[TB] FAIL release_arready: got %b want 1", arready); end
    checks++; if (spi_cs_n !== 1'b1 || state_dbg !== 3'd0) begin failures++; $display("[TB] FAIL release_idle: cs_n=%b state=%0d want 1/0", spi_cs_n, state_dbg); end
  endtask

  task automatic test_single_read();
    bit ok;
    int lat;
    logic [7:0]  cmd_cap;
    logic [23:0] addr_cap;
    model_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_handshake(24'h000100, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL read_handshake: got %b want 1", ok); end
    wait_rvalid(lat);
    checks++; if (lat != EXP_LAT) begin failures++; $display("[TB] FAIL read_latency: got %0d want %0d", lat, EXP_LAT); end
    checks++; if (rdata !== 32'h44332211) begin failures++; $display("[TB] FAIL read_rdata: got %h want 44332211", rdata); end
    checks++; if (rresp !== 2'b00) begin failures++; $display("[TB] FAIL read_rresp: got %b want 00", rresp); end
    checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("[TB] FAIL read_end_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (state_dbg !== 3'd6) begin failures++; $display("[TB] FAIL read_state_resp: got %0d want 6", state_dbg); end
    checks++; if (rises != EXP_RISES) begin failures++; $display("[TB] FAIL read_sclk_count: got %0d want %0d", rises, EXP_RISES); end
`ifndef QSPI_QUAD_EN
    cmd_cap  = '0;
    addr_cap = '0;
    for (int b = 0; b < 8; b++)  cmd_cap  = {cmd_cap[6:0], rise_io[b][0]};
    for (int b = 8; b < 32; b++) addr_cap = {addr_cap[22:0], rise_io[b][0]};
    checks++; if (cmd_cap !== 8'h03) begin failures++; $display("[TB] FAIL read_cmd: got %h want 03", cmd_cap); end
    checks++; if (addr_cap !== 24'h000100) begin failures++; $display("[TB] FAIL read_addr: got %h want 000100", addr_cap); end
`endif
  endtask

  task automatic test_backpressure();
    int edges0;
    edges0 = sclk_edges;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      checks++; if (rvalid !== 1'b1) begin failures++; $display("[TB] FAIL bp_rvalid[%0d]: got %b want 1", c, rvalid); end
      checks++; if (rdata !== 32'h44332211) begin failures++; $display("[TB] FAIL bp_rdata[%0d]: got %h want 44332211", c, rdata); end
      checks++; if (arready !== 1'b0) begin failures++; $display("[TB] FAIL bp_arready[%0d]: got %b want 0", c, arready); end
      checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("[TB] FAIL bp_cs_n[%0d]: got %b want 1", c, spi_cs_n); end
    end
    checks++; if (sclk_edges != edges0) begin failures++; $display("[TB] FAIL bp_sclk_edges: got %0d want %0d", sclk_edges, edges0); end
    rready = 1'b1;
    @(posedge ACLK);
    #1;
    rready = 1'b0;
    checks++; if (rvalid !== 1'b0) begin failures++; $display("[TB] FAIL bp_rvalid_drop: got %b want 0", rvalid); end
    checks++; if (state_dbg !== 3'd7) begin failures++; $display("[TB] FAIL bp_cshold: got %0d want 7", state_dbg); end
    @(posedge ACLK);
    #1;
    checks++; if (state_dbg !== 3'd0 || arready !== 1'b1) begin failures++; $display("[TB] FAIL bp_idle: state=%0d arready=%b want 0/1", state_dbg, arready); end
  endtask

  task automatic test_back_to_back();
    int n;
    int hi;
    logic [23:0] addr_cap;
    model_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(negedge ACLK);
    araddr  = 24'h000010;
    arvalid = 1'b1;
    rready  = 1'b1;
    n = 0;
    while (rvalid !== 1'b1 && n < 2000) begin @(negedge ACLK); n++; end
    checks++; if (rvalid !== 1'b1 || rdata !== 32'hDDCCBBAA) begin failures++; $display("[TB] FAIL b2b_first: rvalid=%b rdata=%h want 1/ddccbbaa", rvalid, rdata); end
    model_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    araddr = 24'h000400;
    hi = 0;
    while (spi_cs_n === 1'b1 && hi < 100) begin hi++; @(negedge ACLK); end
    checks++; if (hi < CS_MIN || hi >= 100) begin failures++; $display("[TB] FAIL b2b_cs_gap: got %0d cycles want >=%0d", hi, CS_MIN); end
    n = 0;
    while (rvalid !== 1'b1 && n < 2000) begin @(negedge ACLK); n++; end
    arvalid = 1'b0;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h04030201) begin failures++; $display("[TB] FAIL b2b_second: rvalid=%b rdata=%h want 1/04030201", rvalid, rdata); end
`ifndef QSPI_QUAD_EN
    addr_cap = '0;
    for (int b = 8; b < 32; b++) addr_cap = {addr_cap[22:0], rise_io[b][0]};
    checks++; if (addr_cap !== 24'h000400) begin failures++; $display("[TB] FAIL b2b_addr: got %h want 000400", addr_cap); end
`endif
    @(negedge ACLK);
    rready = 1'b0;
    repeat (4) @(negedge ACLK);
    checks++; if (state_dbg !== 3'd0 || rvalid !== 1'b0 || spi_cs_n !== 1'b1) begin failures++; $display("[TB] FAIL b2b_idle: state=%0d rvalid=%b cs_n=%b want 0/0/1", state_dbg, rvalid, spi_cs_n); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat;
    int n;
    model_bytes = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    do_handshake(24'h000200, ok);
    n = 0;
    while (state_dbg !== 3'd5 && n < 2000) begin @(posedge ACLK); #1; n++; end
    checks++; if (state_dbg !== 3'd5) begin failures++; $display("[TB] FAIL mid_reach_data: got %0d want 5", state_dbg); end
    repeat (10) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("[TB] FAIL mid_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (spi_sclk !== 1'b0) begin failures++; $display("[TB] FAIL mid_sclk: got %b want 0", spi_sclk); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rvalid: got %b want 0", rvalid); end
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("[TB] FAIL mid_state: got %0d want 0", state_dbg); end
    @(negedge ACLK);
    ARESET = 1'b0;
    do_handshake(24'h000200, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL mid_rehandshake: got %b want 1", ok); end
    wait_rvalid(lat);
    checks++; if (lat != EXP_LAT) begin failures++; $display("[TB] FAIL mid_latency: got %0d want %0d", lat, EXP_LAT); end
    checks++; if (rdata !== 32'hC33CA55A) begin failures++; $display("[TB] FAIL mid_rdata: got %h want c33ca55a", rdata); end
    release_resp();
  endtask

`ifdef QSPI_QUAD_EN
  task automatic test_quad();
    bit ok;
    int lat;
    logic [7:0]  cmd_cap;
    logic [23:0] addr_cap;
    logic [7:0]  mode_cap;
    model_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_handshake(24'hABCDEF, ok);
    wait_rvalid(lat);
    checks++; if (lat != 112) begin failures++; $display("[TB] FAIL quad_latency: got %0d want 112", lat); end
    checks++; if (rdata !== 32'h78563412) begin failures++; $display("[TB] FAIL quad_rdata: got %h want 78563412", rdata); end
    cmd_cap  = '0;
    addr_cap = '0;
    for (int b = 0; b < 8; b++)   cmd_cap  = {cmd_cap[6:0], rise_io[b][0]};
    for (int b = 8; b < 14; b++)  addr_cap = {addr_cap[19:0], rise_io[b]};
    mode_cap = {rise_io[14], rise_io[15]};
    checks++; if (cmd_cap !== 8'hEB) begin failures++; $display("[TB] FAIL quad_cmd: got %h want eb", cmd_cap); end
    checks++; if (addr_cap !== 24'hABCDEF) begin failures++; $display("[TB] FAIL quad_addr: got %h want abcdef", addr_cap); end
    checks++; if (mode_cap !== 8'h00) begin failures++; $display("[TB] FAIL quad_mode: got %h want 00", mode_cap); end
    checks++; if (rises != 28) begin failures++; $display("[TB] FAIL quad_sclk_count: got %0d want 28", rises); end
    release_resp();
  endtask
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_single_read();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef QSPI_QUAD_EN
    test_quad();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
